instr_seq_ctrl: RTL and testbench

Multicycle control sequencer for the RV32I core. It fetches an instruction over a ready/valid memory handshake and latches it into the instruction register. It classifies the opcode into the 4-bit instruction-type code consumed by the immediate generator, pulsing that block's write enable, then walks the datapath through execute, memory and write-back. It also detects illegal opcodes and memory-handshake timeouts, and halts the core on either.

---
 rtl/instr_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_instr_seq_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_seq_ctrl.sv
// rtl/instr_seq_ctrl.sv - multicycle fetch/decode/execute/memory/write-back sequencer for the RV32I core
module instr_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [3:0]  imm_instr_type,
    output logic        imm_wr_en,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic        pc_sel_jalr,
    output logic        illegal,
    output logic        fault,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] T_NONE   = 4'b0000;
    localparam logic [3:0] T_R      = 4'b0001;
    localparam logic [3:0] T_IALU   = 4'b0010;
    localparam logic [3:0] T_LOAD   = 4'b0011;
    localparam logic [3:0] T_JALR   = 4'b0100;
    localparam logic [3:0] T_SYS    = 4'b0101;
    localparam logic [3:0] T_STORE  = 4'b0110;

    localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

    logic [7:0] wait_cnt;
    logic [2:0] state_nx;
    logic [3:0] code_nx;
    logic       fetch_xfer;
    logic       fetch_wait;
    logic       mem_xfer;
    logic       mem_wait;
    logic       timeout_hit;

    // Opcode to immediate-generator type code; unknown opcodes map to T_NONE
    function automatic logic [3:0] classify(input logic [6:0] opcode);
        case (opcode)
            7'b0110011: classify = T_R;
            7'b0010011: classify = T_IALU;
            7'b0000011: classify = T_LOAD;
            7'b1100111: classify = T_JALR;
            7'b1110011: classify = T_SYS;
            7'b0100011: classify = T_STORE;
            default:    classify = T_NONE;
        endcase
    endfunction

    // Handshake qualification and next-state selection
    always_comb begin
        fetch_xfer  = (state == S_FETCH) && imem_req && imem_ready;
        fetch_wait  = (state == S_FETCH) && imem_req && !imem_ready;
        mem_xfer    = (state == S_MEM) && dmem_req && dmem_ready;
        mem_wait    = (state == S_MEM) && dmem_req && !dmem_ready;
        // A ready arriving while the counter sits at the limit still wins
        timeout_hit = (fetch_wait || mem_wait) && (wait_cnt == TIMEOUT);
        code_nx     = fetch_xfer ? classify(imem_rdata[6:0]) : imm_instr_type;
        state_nx    = state;
        case (state)
            S_FETCH: begin
                if (fetch_xfer)       state_nx = S_DECODE;
                else if (timeout_hit) state_nx = S_HALT;
            end
            S_DECODE: state_nx = (imm_instr_type == T_NONE) ? S_HALT : S_EXEC;
            S_EXEC: begin
                case (imm_instr_type)
                    T_LOAD, T_STORE: state_nx = S_MEM;
                    T_SYS:           state_nx = S_HALT;
                    default:         state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_xfer)         state_nx = S_WB;
                else if (timeout_hit) state_nx = S_HALT;
            end
            S_WB:    state_nx = S_FETCH;
            default: state_nx = S_HALT;
        endcase
    end

    // State, instruction register, registered strobes for the upcoming state, and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_FETCH;
            ir             <= 32'h0;
            imm_instr_type <= T_NONE;
            imem_req       <= 1'b0;
            imm_wr_en      <= 1'b0;
            alu_src_imm    <= 1'b0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            reg_we         <= 1'b0;
            wb_sel         <= 2'b00;
            pc_we          <= 1'b0;
            pc_sel_jalr    <= 1'b0;
            illegal        <= 1'b0;
            fault          <= 1'b0;
            wait_cnt       <= 8'd0;
        end else begin
            state          <= state_nx;
            imm_instr_type <= code_nx;
            if (fetch_xfer) begin
                ir <= imem_rdata;
            end
            imem_req    <= (state_nx == S_FETCH);
            imm_wr_en   <= (state_nx == S_DECODE);
            alu_src_imm <= (state_nx == S_EXEC) &&
                           (code_nx inside {T_IALU, T_LOAD, T_JALR, T_STORE});
            dmem_req    <= (state_nx == S_MEM);
            dmem_we     <= (state_nx == S_MEM) && (code_nx == T_STORE);
            pc_we       <= (state_nx == S_WB);
            reg_we      <= (state_nx == S_WB) && (ir[11:7] != 5'd0) &&
                           (code_nx inside {T_R, T_IALU, T_LOAD, T_JALR});
            pc_sel_jalr <= (state_nx == S_WB) && (code_nx == T_JALR);
            if (state_nx == S_WB && code_nx == T_LOAD)      wb_sel <= 2'b01;
            else if (state_nx == S_WB && code_nx == T_JALR) wb_sel <= 2'b10;
            else                                            wb_sel <= 2'b00;
            illegal <= illegal || ((state == S_DECODE) && (imm_instr_type == T_NONE));
            fault   <= fault || timeout_hit;
            // Counter restarts on every state change so each FETCH/MEM visit starts from zero
            if (state_nx != state)            wait_cnt <= 8'd0;
            else if (fetch_wait || mem_wait)  wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb/tb_instr_seq_ctrl.sv - directed self-checking bench for instr_seq_ctrl
module tb_instr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [3:0]  imm_instr_type;
    logic        imm_wr_en;
    logic        alu_src_imm;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic        pc_sel_jalr;
    logic        illegal;
    logic        fault;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    instr_seq_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir(ir), .imm_instr_type(imm_instr_type), .imm_wr_en(imm_wr_en),
        .alu_src_imm(alu_src_imm), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .reg_we(reg_we), .wb_sel(wb_sel), .pc_we(pc_we),
        .pc_sel_jalr(pc_sel_jalr), .illegal(illegal), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    // {imem_req, imm_wr_en, alu_src_imm, dmem_req, dmem_we, reg_we, wb_sel[1:0], pc_we, pc_sel_jalr}
    function automatic logic [9:0] strb();
        return {imem_req, imm_wr_en, alu_src_imm, dmem_req, dmem_we, reg_we, wb_sel, pc_we, pc_sel_jalr};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; dmem_ready = 1'b0;
        cyc(); cyc();
        chk("rst_state", 32'(state), 0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_type", 32'(imm_instr_type), 0);
        chk("rst_strobes", 32'(strb()), 0);
        chk("rst_flags", 32'({illegal, fault}), 0);

        // addi x1,x0,5
        rst_n = 1'b1; cyc();
        chk("first_req", 32'(strb()), 32'(10'b1000000000));
        imem_ready = 1'b1; imem_rdata = 32'h00500093;
        cyc();
        chk("addi_ir", ir, 32'h00500093);
        chk("addi_type", 32'(imm_instr_type), 4'b0010);
        chk("addi_dec", 32'(strb()), 32'(10'b0100000000));
        chk("addi_state", 32'(state), 1);
        imem_ready = 1'b0;
        cyc();
        chk("addi_exec", 32'(strb()), 32'(10'b0010000000));
        chk("addi_type_hold", 32'(imm_instr_type), 4'b0010);
        cyc();
        chk("addi_wb", 32'(strb()), 32'(10'b0000010010));
        cyc();
        chk("addi_next_req", 32'(strb()), 32'(10'b1000000000));
        chk("addi_next_state", 32'(state), 0);

        // lw x5,8(x2) with dmem_ready three cycles late
        imem_ready = 1'b1; imem_rdata = 32'h00812283;
        cyc();
        chk("lw_type", 32'(imm_instr_type), 4'b0011);
        chk("lw_dec", 32'(strb()), 32'(10'b0100000000));
        imem_ready = 1'b0;
        cyc();
        chk("lw_exec", 32'(strb()), 32'(10'b0010000000));
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("lw_mem", 32'(strb()), 32'(10'b0001000000));
            if (i == 3) dmem_ready = 1'b1;
        end
        cyc();
        dmem_ready = 1'b0;
        chk("lw_wb", 32'(strb()), 32'(10'b0000010110));
        cyc();
        chk("lw_next_req", 32'(strb()), 32'(10'b1000000000));

        // sw
        imem_ready = 1'b1; imem_rdata = 32'h00512223;
        cyc();
        chk("sw_type", 32'(imm_instr_type), 4'b0110);
        imem_ready = 1'b0;
        cyc();
        chk("sw_exec", 32'(strb()), 32'(10'b0010000000));
        cyc();
        chk("sw_mem", 32'(strb()), 32'(10'b0001100000));
        dmem_ready = 1'b1;
        cyc();
        dmem_ready = 1'b0;
        chk("sw_wb", 32'(strb()), 32'(10'b0000000010));
        cyc();
        chk("sw_next_req", 32'(strb()), 32'(10'b1000000000));

        // jalr x1,0(x1)
        imem_ready = 1'b1; imem_rdata = 32'h000080E7;
        cyc();
        chk("jalr_type", 32'(imm_instr_type), 4'b0100);
        imem_ready = 1'b0;
        cyc();
        chk("jalr_exec", 32'(strb()), 32'(10'b0010000000));
        cyc();
        chk("jalr_wb", 32'(strb()), 32'(10'b0000011011));
        cyc();
        chk("jalr_next_req", 32'(strb()), 32'(10'b1000000000));

        // LUI is unsupported: illegal halt, ready afterwards ignored
        imem_ready = 1'b1; imem_rdata = 32'h000010B7;
        cyc();
        chk("lui_type", 32'(imm_instr_type), 4'b0000);
        chk("lui_dec", 32'(strb()), 32'(10'b0100000000));
        cyc();
        chk("lui_state", 32'(state), 5);
        chk("lui_flags", 32'({illegal, fault}), 32'(2'b10));
        chk("lui_halt_strb", 32'(strb()), 0);
        cyc(); cyc();
        chk("lui_stay_halt", 32'({state, strb()}), 32'({3'd5, 10'b0}));

        // reset out of HALT, then ecall
        rst_n = 1'b0; imem_ready = 1'b0;
        cyc();
        chk("halt_rst", 32'({state, illegal, fault, strb()}), 0);
        rst_n = 1'b1;
        cyc();
        chk("ecall_req", 32'(strb()), 32'(10'b1000000000));
        imem_ready = 1'b1; imem_rdata = 32'h00000073;
        cyc();
        chk("ecall_type", 32'(imm_instr_type), 4'b0101);
        imem_ready = 1'b0;
        cyc();
        chk("ecall_exec", 32'({state, strb()}), 32'({3'd2, 10'b0}));
        cyc();
        chk("ecall_halt", 32'({state, illegal, fault, strb()}), 32'({3'd5, 2'b00, 10'b0}));

        // fetch timeout: 15 ready-low cycles tolerated, 16th faults
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 15; i++) begin
            cyc();
            chk("to_wait", 32'({fault, strb()}), 32'({1'b0, 10'b1000000000}));
        end
        cyc();
        chk("to_fault", 32'({state, illegal, fault, strb()}), 32'({3'd5, 2'b01, 10'b0}));

        // ready arrives when the counter is at the limit: transfer wins (addi x0)
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 15; i++) cyc();
        chk("edge_req", 32'(strb()), 32'(10'b1000000000));
        imem_ready = 1'b1; imem_rdata = 32'h00500013;
        cyc();
        imem_ready = 1'b0;
        chk("edge_dec", 32'({state, fault}), 32'({3'd1, 1'b0}));
        chk("edge_ir", ir, 32'h00500013);
        cyc(); cyc();
        chk("rd0_wb", 32'(strb()), 32'(10'b0000000010));
        cyc();

        // reset in the middle of a load's MEM phase
        imem_ready = 1'b1; imem_rdata = 32'h00812283;
        cyc();
        imem_ready = 1'b0;
        cyc(); cyc();
        chk("mrst_mem", 32'(strb()), 32'(10'b0001000000));
        rst_n = 1'b0;
        cyc();
        chk("mrst_zero", 32'({state, imm_instr_type, illegal, fault, strb()}), 0);
        chk("mrst_ir", ir, 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("mrst_req", 32'({state, strb()}), 32'({3'd0, 10'b1000000000}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
